float_add_seq: RTL and testbench

Multi-cycle IEEE-754 single-precision adder/subtractor, built as a controller FSM around one shared significand datapath. It sequences unpack/swap, one-bit-per-cycle alignment, add, iterative normalization, round-to-nearest-even and a renormalize-on-round-carry pass. It sits between the float unit's operand registers and the result bus, using a start/busy/done handshake.

---
 rtl/float_pkg.sv | 30 +++
 rtl/float_special_case.sv | 40 ++++
 rtl/float_add_seq.sv | 201 ++++++++++++++++++++
 tb/tb_float_add_seq.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/float_pkg.sv
// Shared widths, significand bit positions, constants and controller states
// for the sequential single-precision adder.
package float_pkg;

    localparam int unsigned EXP_W   = 8;
    localparam int unsigned FRAC_W  = 23;
    localparam int unsigned SIG_W   = 28;
    localparam int unsigned IEXP_W  = 10;

    localparam int unsigned BIT_S      = 0;
    localparam int unsigned BIT_R      = 1;
    localparam int unsigned BIT_G      = 2;
    localparam int unsigned BIT_L      = 3;
    localparam int unsigned BIT_HIDDEN = 26;
    localparam int unsigned BIT_CARRY  = 27;

    localparam logic [31:0]      QNAN    = 32'h7FC0_0000;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'd255;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_ADD,
        ST_NORM,
        ST_ROUND,
        ST_SPECIAL,
        ST_PACK
    } state_e;

endpackage

// File: rtl/float_special_case.sv
// Classifies an operand pair (NaN/inf/zero) and produces the result that
// bypasses the significand datapath. Exp=0 operands count as signed zero.
module float_special_case
    import float_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        is_special_o,
    output logic [31:0] result_o
);

    logic [EXP_W-1:0] ea, eb;
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    assign ea     = a_i[30:23];
    assign eb     = b_i[30:23];
    assign a_nan  = (&ea) && (|a_i[FRAC_W-1:0]);
    assign b_nan  = (&eb) && (|b_i[FRAC_W-1:0]);
    assign a_inf  = (&ea) && !(|a_i[FRAC_W-1:0]);
    assign b_inf  = (&eb) && !(|b_i[FRAC_W-1:0]);
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);

    always_comb begin
        is_special_o = (&ea) | (&eb) | a_zero | b_zero;
        result_o     = a_i;
        if (a_nan || b_nan || (a_inf && b_inf && (a_i[31] != b_i[31]))) begin
            result_o = QNAN;
        end else if (a_inf) begin
            result_o = a_i;
        end else if (b_inf) begin
            result_o = b_i;
        end else if (a_zero && b_zero) begin
            result_o = {a_i[31] & b_i[31], 31'd0};
        end else if (a_zero) begin
            result_o = b_i;
        end
    end

endmodule

// File: rtl/float_add_seq.sv
// Multi-cycle IEEE-754 single adder/subtractor: a controller FSM sequencing
// one shared significand datapath through align, add, normalize and round.
module float_add_seq
    import float_pkg::*;
#(
    parameter int unsigned ALIGN_CAP = 26
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        op_sub,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow
);

    localparam logic [EXP_W-1:0] ALIGN_CAP_E = EXP_W'(ALIGN_CAP);

    state_e             state_q, state_d;
    logic               sign_q, sign_d;
    logic [IEXP_W-1:0]  exp_q, exp_d;
    logic [SIG_W-1:0]   sig_q, sig_d;
    logic [SIG_W-1:0]   sigy_q, sigy_d;
    logic [EXP_W-1:0]   d_q, d_d;
    logic               eff_sub_q, eff_sub_d;
    logic               spec_q, spec_d;
    logic [31:0]        spec_res_q, spec_res_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [31:0]        result_q, result_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;

    logic [31:0]        b_eff, x_op, y_op, spec_res_c;
    logic               is_special_c, a_big_c, round_up_c;
    logic [EXP_W-1:0]   exp_diff_c;
    logic [SIG_W-1:0]   sum_c, rnd_c;

    assign b_eff      = {b[31] ^ op_sub, b[30:0]};
    assign a_big_c    = (a[30:0] >= b_eff[30:0]);
    assign x_op       = a_big_c ? a : b_eff;
    assign y_op       = a_big_c ? b_eff : a;
    assign exp_diff_c = x_op[30:23] - y_op[30:23];
    assign sum_c      = eff_sub_q ? (sig_q - sigy_q) : (sig_q + sigy_q);
    assign rnd_c      = sig_q + SIG_W'(8);
    assign round_up_c = sig_q[BIT_G] & (sig_q[BIT_L] | sig_q[BIT_R] | sig_q[BIT_S]);

    float_special_case u_special (
        .a_i          (a),
        .b_i          (b_eff),
        .is_special_o (is_special_c),
        .result_o     (spec_res_c)
    );

    always_comb begin
        state_d    = state_q;
        sign_d     = sign_q;
        exp_d      = exp_q;
        sig_d      = sig_q;
        sigy_d     = sigy_q;
        d_d        = d_q;
        eff_sub_d  = eff_sub_q;
        spec_d     = spec_q;
        spec_res_d = spec_res_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        result_d   = result_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    busy_d     = 1'b1;
                    ovf_d      = 1'b0;
                    unf_d      = 1'b0;
                    spec_d     = is_special_c;
                    spec_res_d = spec_res_c;
                    sign_d     = x_op[31];
                    exp_d      = IEXP_W'(x_op[30:23]);
                    sig_d      = {2'b01, x_op[FRAC_W-1:0], 3'b000};
                    sigy_d     = {2'b01, y_op[FRAC_W-1:0], 3'b000};
                    d_d        = exp_diff_c;
                    eff_sub_d  = x_op[31] ^ y_op[31];
                    if (is_special_c)            state_d = ST_SPECIAL;
                    else if (exp_diff_c == '0)   state_d = ST_ADD;
                    else                         state_d = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                // Far-apart operands only ever contribute sticky.
                if (d_q > ALIGN_CAP_E) begin
                    sigy_d  = SIG_W'(1);
                    d_d     = '0;
                    state_d = ST_ADD;
                end else begin
                    sigy_d = {1'b0, sigy_q[SIG_W-1:2], sigy_q[1] | sigy_q[0]};
                    d_d    = d_q - EXP_W'(1);
                    if (d_q == EXP_W'(1)) state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                if (sum_c == '0) begin
                    sign_d  = 1'b0;
                    exp_d   = '0;
                    sig_d   = '0;
                    state_d = ST_PACK;
                end else begin
                    sig_d   = sum_c;
                    state_d = ST_NORM;
                end
            end
            ST_NORM: begin
                if (sig_q[BIT_CARRY]) begin
                    sig_d   = {1'b0, sig_q[SIG_W-1:2], sig_q[1] | sig_q[0]};
                    exp_d   = exp_q + IEXP_W'(1);
                    state_d = ST_ROUND;
                end else if (!sig_q[BIT_HIDDEN]) begin
                    if (exp_q == IEXP_W'(1)) begin
                        sig_d   = '0;
                        exp_d   = '0;
                        unf_d   = 1'b1;
                        state_d = ST_PACK;
                    end else begin
                        sig_d = {sig_q[SIG_W-2:0], 1'b0};
                        exp_d = exp_q - IEXP_W'(1);
                    end
                end else begin
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                // A rounding carry needs exactly one more right shift.
                if (round_up_c) sig_d = rnd_c;
                state_d = (round_up_c && rnd_c[BIT_CARRY]) ? ST_NORM : ST_PACK;
            end
            ST_SPECIAL: begin
                state_d = ST_PACK;
            end
            ST_PACK: begin
                if (spec_q) begin
                    result_d = spec_res_q;
                end else if (exp_q >= IEXP_W'(EXP_MAX)) begin
                    result_d = {sign_q, EXP_MAX, FRAC_W'(0)};
                    ovf_d    = 1'b1;
                end else begin
                    result_d = {sign_q, exp_q[EXP_W-1:0], sig_q[25:3]};
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sign_q     <= 1'b0;
            exp_q      <= '0;
            sig_q      <= '0;
            sigy_q     <= '0;
            d_q        <= '0;
            eff_sub_q  <= 1'b0;
            spec_q     <= 1'b0;
            spec_res_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sign_q     <= sign_d;
            exp_q      <= exp_d;
            sig_q      <= sig_d;
            sigy_q     <= sigy_d;
            d_q        <= d_d;
            eff_sub_q  <= eff_sub_d;
            spec_q     <= spec_d;
            spec_res_q <= spec_res_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_float_add_seq.sv
// Self-checking bench for float_add_seq: vector table driven back-to-back
// through a scoreboard, plus busy-start, and mid-operation reset sequences.
module tb_float_add_seq;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, start, op_sub;
    logic [31:0] a, b, result;
    logic        busy, done, overflow, underflow;

    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    vec_t vecs[$];
    vec_t sb[$];

    float_add_seq #(.ALIGN_CAP(26)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .op_sub    (op_sub),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_total++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp_v);
    endtask

    function automatic vec_t mk(input string n, input logic [31:0] av, input logic [31:0] bv,
                                input logic s, input logic [31:0] r, input logic o,
                                input logic u, input int l);
        vec_t v;
        v.name = n; v.a = av; v.b = bv; v.sub = s;
        v.res = r; v.ovf = o; v.unf = u; v.lat = l;
        return v;
    endfunction

    // Called at a negedge; returns at the negedge where done is seen.
    task automatic apply(input vec_t v);
        int   t0;
        int   waited;
        vec_t e;
        a = v.a; b = v.b; op_sub = v.sub; start = 1'b1;
        sb.push_back(v);
        t0 = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        check({v.name, " busy"}, 32'(busy), 32'd1);
        check({v.name, " done_pulse"}, 32'(done), 32'd0);
        waited = 0;
        while (!done && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check({v.name, " done_seen"}, 32'(done), 32'd1);
        e = sb.pop_front();
        if (!done) return;
        check({e.name, " result"}, result, e.res);
        check({e.name, " overflow"}, 32'(overflow), 32'(e.ovf));
        check({e.name, " underflow"}, 32'(underflow), 32'(e.unf));
        check({e.name, " busy_low"}, 32'(busy), 32'd0);
        if (e.lat != 0) check({e.name, " latency"}, 32'(cyc - t0), 32'(e.lat));
    endtask

    initial begin
        int   n_done;
        vec_t e;

        vecs.push_back(mk("one_plus_one",  32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0, 4));
        vecs.push_back(mk("one_minus_one", 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 1'b0, 0));
        vecs.push_back(mk("tie_even",      32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 28));
        vecs.push_back(mk("tie_odd",       32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 1'b0, 1'b0, 28));
        vecs.push_back(mk("round_carry",   32'h3F7FFFFF, 32'h33000000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 30));
        vecs.push_back(mk("overflow",      32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0, 4));
        vecs.push_back(mk("inf_minus_inf", 32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 1'b0, 1'b0, 2));
        vecs.push_back(mk("denorm_plus_x", 32'h00000001, 32'h40400000, 1'b0, 32'h40400000, 1'b0, 1'b0, 2));
        vecs.push_back(mk("two_minus_one", 32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 1'b0, 1'b0, 6));
        vecs.push_back(mk("1p5_plus_2p5",  32'h3FC00000, 32'h40200000, 1'b0, 32'h40800000, 1'b0, 1'b0, 5));
        vecs.push_back(mk("neg_plus_neg",  32'hBF800000, 32'hBF800000, 1'b0, 32'hC0000000, 1'b0, 1'b0, 4));
        vecs.push_back(mk("one_minus_3",   32'h3F800000, 32'h40400000, 1'b1, 32'hC0000000, 1'b0, 1'b0, 5));
        vecs.push_back(mk("align_d26",     32'h3F800000, 32'h32800000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 30));
        vecs.push_back(mk("align_d27_cap", 32'h3F800000, 32'h32000000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 5));
        vecs.push_back(mk("align_d30_cap", 32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 5));
        vecs.push_back(mk("flush_zero",    32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 1'b0, 1'b1, 0));
        vecs.push_back(mk("nan_in",        32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0, 1'b0, 2));
        vecs.push_back(mk("inf_plus_one",  32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 1'b0, 1'b0, 2));
        vecs.push_back(mk("nzero_nzero",   32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b0, 1'b0, 2));
        vecs.push_back(mk("nzero_pzero",   32'h80000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 2));
        vecs.push_back(mk("zero_plus_x",   32'h00000000, 32'hC0A00000, 1'b0, 32'hC0A00000, 1'b0, 1'b0, 2));
        vecs.push_back(mk("ninf_sub_ninf", 32'hFF800000, 32'hFF800000, 1'b1, 32'h7FC00000, 1'b0, 1'b0, 2));

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; op_sub = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);
        check("reset overflow", 32'(overflow), 32'd0);
        check("reset underflow", 32'(underflow), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back: each new start lands in the previous done cycle.
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        // Start pulse while busy must be ignored.
        @(negedge clk);
        a = 32'h3F800000; b = 32'h3F800000; op_sub = 1'b0; start = 1'b1;
        sb.push_back(mk("busy_start", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0, 4));
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 32'h40A00000; b = 32'h40A00000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check({e.name, " result"}, result, e.res);
                end
            end
        end
        check("busy_start done_count", 32'(n_done), 32'd1);

        // Reset during alignment discards the in-flight operation.
        a = 32'h3F800000; b = 32'h33800000; op_sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst result", result, 32'd0);
        check("midrst overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("midrst no_done", 32'(n_done), 32'd0);
        apply(mk("post_reset", 32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 1'b0, 1'b0, 28));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
